// File: rtl/pipe_mux_if.sv
// Handshake bundle for pipe_mux: flattened input channels with valid/ready
// upstream, registered selected beat with valid/ready downstream, and flush.
interface pipe_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [WIDTH*NUM_IN-1:0] iData;
  logic [SEL_W-1:0]        iControl;
  logic                    iValid;
  logic                    oReady;
  logic                    iFlush;
  logic [WIDTH-1:0]        oData;
  logic [SEL_W-1:0]        oControl;
  logic                    oValid;
  logic                    iReady;

  // Mux side: consumes the upstream beat, produces the selected beat.
  modport slave (
    input  iData, iControl, iValid, iFlush, iReady,
    output oReady, oData, oControl, oValid
  );

  // Environment side: drives upstream and downstream handshakes.
  modport master (
    output iData, iControl, iValid, iFlush, iReady,
    input  oReady, oData, oControl, oValid
  );
endinterface

// File: rtl/pipe_mux.sv
// Registered N:1 channel mux with a two-entry skid buffer so oReady is a
// flop output while still sustaining one beat per cycle.
module pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input logic      iClk,
  input logic      iReset,
  pipe_mux_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           nextState;
  logic             readyReg;
  logic [WIDTH-1:0] mainData;
  logic [SEL_W-1:0] mainCtrl;
  logic [WIDTH-1:0] skidData;
  logic [SEL_W-1:0] skidCtrl;

  logic             accept;
  logic             drain;
  logic             loadMainFromIn;
  logic             loadMainFromSkid;
  logic             loadSkid;
  int               selIdx;
  logic [WIDTH-1:0] selData;

  assign accept = bus.iValid && readyReg;
  assign drain  = (state != EMPTY) && bus.iReady;

  // Selects at or above the last channel all map onto the last channel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    selIdx  = NUM_IN - 1;
    selData = '0;
    if (int'(bus.iControl) < NUM_IN - 1)
      selIdx = int'(bus.iControl);
    for (int k = 0; k < NUM_IN; k++)
      if (k == selIdx)
        selData = bus.iData[k*WIDTH +: WIDTH];
  end

  always_comb begin
    nextState        = state;
    loadMainFromIn   = 1'b0;
    loadMainFromSkid = 1'b0;
    loadSkid         = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          nextState      = ONE;
          loadMainFromIn = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          loadMainFromIn = 1'b1;
        end else if (accept) begin
          nextState = TWO;
          loadSkid  = 1'b1;
        end else if (drain) begin
          nextState = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          nextState        = ONE;
          loadMainFromSkid = 1'b1;
        end
      end
      default: nextState = EMPTY;
    endcase
    // Flush drops everything but leaves the data registers untouched.
    if (bus.iFlush) begin
      nextState        = EMPTY;
      loadMainFromIn   = 1'b0;
      loadMainFromSkid = 1'b0;
      loadSkid         = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    // NOTE: data registers are reset too, because oData/oControl must read zero out of reset.
    if (iReset) begin
      state    <= EMPTY;
      readyReg <= 1'b1;
      mainData <= '0;
      mainCtrl <= '0;
      skidData <= '0;
      skidCtrl <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state    <= nextState;
      readyReg <= (nextState != TWO);
      if (loadMainFromIn) begin
        mainData <= selData;
        mainCtrl <= bus.iControl;
      end else if (loadMainFromSkid) begin
        mainData <= skidData;
        mainCtrl <= skidCtrl;
      end
      if (loadSkid) begin
        skidData <= selData;
        skidCtrl <= bus.iControl;
      end
    end
  end

  assign bus.oReady   = readyReg;
  assign bus.oValid   = (state != EMPTY);
  assign bus.oData    = mainData;
  assign bus.oControl = mainCtrl;

endmodule

// File: tb/tb_pipe_mux.sv
// Self-checking bench for pipe_mux: directed scenarios plus a randomized run
// scored against a two-deep FIFO model of the stage.
module tb_pipe_mux;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  ctrl;
  } beat_t;

  logic iClk = 1'b0;
  logic iReset;
  int   nChecks = 0;
  int   nFails  = 0;

  pipe_mux_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus ();
  pipe_mux_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bus3 ();

  pipe_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
    .iClk  (iClk),
    .iReset(iReset),
    .bus   (bus)
  );

  pipe_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
    .iClk  (iClk),
    .iReset(iReset),
    .bus   (bus3)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Random data on every channel, then the chosen channel overwritten.
  task automatic present(input int ch, input logic [31:0] v, input logic [1:0] ctrl);
    for (int k = 0; k < 4; k++) bus.iData[k*32 +: 32] = $urandom;
    bus.iData[ch*32 +: 32] = v;
    bus.iControl = ctrl;
    bus.iValid   = 1'b1;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    bus.iReady  = 1'b1;
    bus3.iReady = 1'b1;
    present(1, 32'hDEAD_BEEF, 2'd1);
    bus3.iData    = {$urandom, $urandom, $urandom};
    bus3.iControl = 2'd2;
    bus3.iValid   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      nChecks++;
      if ({bus.oValid, bus.oReady, bus.oControl, bus.oData} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
        nFails++;
        $display("FAIL reset: v/r/ctl/data=%b/%b/%0d/%h expected 0/1/0/00000000",
                 bus.oValid, bus.oReady, bus.oControl, bus.oData);
      end
      nChecks++;
      if ({bus3.oValid, bus3.oReady, bus3.oControl, bus3.oData} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
        nFails++;
        $display("FAIL reset3: v/r/ctl/data=%b/%b/%0d/%h expected 0/1/0/00000000",
                 bus3.oValid, bus3.oReady, bus3.oControl, bus3.oData);
      end
    end
    iReset      = 1'b0;
    bus.iValid  = 1'b0;
    bus3.iValid = 1'b0;
  endtask

  // Starts on the very first cycle out of reset.
  task automatic test_single_beat();
    present(2, 32'h0000_00A2, 2'd2);
    bus.iReady = 1'b1;
    tick();
    nChecks++;
    if ({bus.oValid, bus.oControl, bus.oData} !== {1'b1, 2'd2, 32'h0000_00A2}) begin
      nFails++;
      $display("FAIL single_beat: v/ctl/data=%b/%0d/%h expected 1/2/000000a2",
               bus.oValid, bus.oControl, bus.oData);
    end
    bus.iValid = 1'b0;
    tick();
    nChecks++;
    if (bus.oValid !== 1'b0) begin
      nFails++;
      $display("FAIL single_beat_after: oValid=%b expected 0", bus.oValid);
    end
  endtask

  task automatic test_backpressure();
    bus.iReady = 1'b0;
    present(0, 32'h11, 2'd0);
    tick();
    nChecks++;
    if ({bus.oValid, bus.oReady, bus.oData} !== {1'b1, 1'b1, 32'h11}) begin
      nFails++;
      $display("FAIL bp_first: v/r/data=%b/%b/%h expected 1/1/00000011",
               bus.oValid, bus.oReady, bus.oData);
    end
    present(1, 32'h22, 2'd1);
    tick();
    bus.iValid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      nChecks++;
      if ({bus.oValid, bus.oReady, bus.oControl, bus.oData} !== {1'b1, 1'b0, 2'd0, 32'h11}) begin
        nFails++;
        $display("FAIL bp_full: v/r/ctl/data=%b/%b/%0d/%h expected 1/0/0/00000011",
                 bus.oValid, bus.oReady, bus.oControl, bus.oData);
      end
      tick();
    end
    // The iReady=0 cycles above held; now release and watch two drains.
    bus.iReady = 1'b1;
    tick();
    nChecks++;
    if ({bus.oValid, bus.oReady, bus.oControl, bus.oData} !== {1'b1, 1'b1, 2'd1, 32'h22}) begin
      nFails++;
      $display("FAIL bp_second: v/r/ctl/data=%b/%b/%0d/%h expected 1/1/1/00000022",
               bus.oValid, bus.oReady, bus.oControl, bus.oData);
    end
    tick();
    nChecks++;
    if ({bus.oValid, bus.oReady} !== 2'b01) begin
      nFails++;
      $display("FAIL bp_drained: v/r=%b/%b expected 0/1", bus.oValid, bus.oReady);
    end
  endtask

  task automatic test_flush();
    bus.iReady = 1'b0;
    present(0, 32'h11, 2'd0);
    tick();
    present(1, 32'h22, 2'd1);
    tick();
    nChecks++;
    if (bus.oReady !== 1'b0) begin
      nFails++;
      $display("FAIL flush_setup: oReady=%b expected 0", bus.oReady);
    end
    present(3, 32'h33, 2'd3);
    bus.iFlush = 1'b1;
    tick();
    nChecks++;
    if ({bus.oValid, bus.oReady} !== 2'b01) begin
      nFails++;
      $display("FAIL flush: v/r=%b/%b expected 0/1", bus.oValid, bus.oReady);
    end
    bus.iFlush = 1'b0;
    bus.iValid = 1'b0;
    bus.iReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      nChecks++;
      if (bus.oValid !== 1'b0) begin
        nFails++;
        $display("FAIL flush_quiet: oValid=%b data=%h expected no beat", bus.oValid, bus.oData);
      end
    end
  endtask

  task automatic test_reset_in_two();
    bus.iReady = 1'b0;
    present(2, 32'h44, 2'd2);
    tick();
    present(3, 32'h55, 2'd3);
    tick();
    iReset     = 1'b1;
    bus.iFlush = 1'b0;
    bus.iReady = 1'b1;
    present(1, 32'h66, 2'd1);
    tick();
    nChecks++;
    if ({bus.oValid, bus.oReady, bus.oControl, bus.oData} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      nFails++;
      $display("FAIL reset_in_two: v/r/ctl/data=%b/%b/%0d/%h expected 0/1/0/00000000",
               bus.oValid, bus.oReady, bus.oControl, bus.oData);
    end
    iReset     = 1'b0;
    bus.iValid = 1'b0;
    tick();
    nChecks++;
    if (bus.oValid !== 1'b0) begin
      nFails++;
      $display("FAIL reset_in_two_after: oValid=%b expected 0 (skid not cleared)", bus.oValid);
    end
  endtask

  // Three-channel instance: selects 2 and 3 both land on channel 2.
  task automatic test_out_of_range();
    logic [1:0]  seq[5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [31:0] ch[3];
    logic [31:0] exp;
    bus3.iReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3; k++) ch[k] = $urandom;
      if (i == 0) ch[2] = 32'hC3;
      bus3.iData    = {ch[2], ch[1], ch[0]};
      bus3.iControl = seq[i];
      bus3.iValid   = 1'b1;
      exp = (seq[i] > 2'd2) ? ch[2] : ch[seq[i]];
      tick();
      nChecks++;
      if ({bus3.oValid, bus3.oControl, bus3.oData} !== {1'b1, seq[i], exp}) begin
        nFails++;
        $display("FAIL out_of_range[%0d]: v/ctl/data=%b/%0d/%h expected 1/%0d/%h",
                 i, bus3.oValid, bus3.oControl, bus3.oData, seq[i], exp);
      end
    end
    bus3.iValid = 1'b0;
    tick();
    nChecks++;
    if (bus3.oValid !== 1'b0) begin
      nFails++;
      $display("FAIL out_of_range_end: oValid=%b expected 0", bus3.oValid);
    end
  endtask

  task automatic test_streaming();
    bus.iReady = 1'b1;
    present(1 % 4, 32'h1, 2'(1 % 4));
    for (int i = 1; i <= 8; i++) begin
      tick();
      nChecks++;
      if ({bus.oValid, bus.oData} !== {1'b1, 32'(i)}) begin
        nFails++;
        $display("FAIL stream[%0d]: v/data=%b/%h expected 1/%h", i, bus.oValid, bus.oData, 32'(i));
      end
      if (i < 8) present((i + 1) % 4, 32'(i + 1), 2'((i + 1) % 4));
      else bus.iValid = 1'b0;
    end
    tick();
    nChecks++;
    if (bus.oValid !== 1'b0) begin
      nFails++;
      $display("FAIL stream_end: oValid=%b expected 0", bus.oValid);
    end
  endtask

  // The stage behaves as a FIFO of depth two whose ready reflects the
  // occupancy left by the previous edge.
  task automatic test_random();
    beat_t q[$];
    beat_t b;
    logic  acc;
    logic  drn;
    int    ch;
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      nChecks++;
      if ({bus.oValid, bus.oReady} !== {q.size() > 0, q.size() < 2}) begin
        nFails++;
        $display("FAIL random_hs[%0d]: v/r=%b/%b expected %b/%b",
                 c, bus.oValid, bus.oReady, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        nChecks++;
        if ({bus.oControl, bus.oData} !== {q[0].ctrl, q[0].data}) begin
          nFails++;
          $display("FAIL random_data[%0d]: ctl/data=%0d/%h expected %0d/%h",
                   c, bus.oControl, bus.oData, q[0].ctrl, q[0].data);
        end
      end
      ch = $urandom_range(3);
      b.data = $urandom;
      b.ctrl = 2'(ch);
      present(ch, b.data, b.ctrl);
      bus.iValid = ($urandom_range(3) != 0);
      bus.iReady = ($urandom_range(2) != 0);
      bus.iFlush = ($urandom_range(31) == 0);
      acc = bus.iValid && (q.size() < 2);
      drn = bus.iReady && (q.size() > 0);
      if (bus.iFlush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
      tick();
    end
    bus.iValid = 1'b0;
    bus.iFlush = 1'b0;
  endtask

  initial begin
    iReset        = 1'b1;
    bus.iData     = '0;
    bus.iControl  = '0;
    bus.iValid    = 1'b0;
    bus.iFlush    = 1'b0;
    bus.iReady    = 1'b0;
    bus3.iData    = '0;
    bus3.iControl = '0;
    bus3.iValid   = 1'b0;
    bus3.iFlush   = 1'b0;
    bus3.iReady   = 1'b0;

    test_reset();
    test_single_beat();
    test_backpressure();
    test_flush();
    test_reset_in_two();
    test_out_of_range();
    test_streaming();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
